// File: rtl/sdram_vid_pkg.sv
// Shared types and constants for the SDRAM video prefetch engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_vid_pkg;

    // Request handshake with the controller's secondary read port
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    // Controller slot length in clocks (IDLE phase recurs every SLOT_LEN clocks)
    localparam int SLOT_LEN = 6;

    // Default prefetch FIFO depth
    localparam int DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/vid_fifo.sv
// Synchronous byte FIFO with flush and a registered head-of-queue output.
// Latency: pushed byte is poppable next clock; rd_dat updates the clock after pop.
// Backpressure: push when full (without pop) is dropped, pop when empty is ignored, flush wins over both.
module vid_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               rd_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    rd_dat_q, rd_dat_d;
    logic          do_push, do_pop;

    // Next-state for pointers, occupancy and the registered output byte
    always_comb begin
        do_pop   = pop && (count_q != '0) && !flush;
        do_push  = push && !flush && ((count_q != FULL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rd_dat_d = rd_dat_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                rd_dat_d = mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Pointer, count and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_dat_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;
    assign empty  = (count_q == '0);
    assign count  = count_q;

endmodule

// File: rtl/sdram_vid_fetch.sv
// Per-scanline video byte prefetch from the SDRAM controller's port 2 into a small FIFO.
// Latency: best case one byte per two controller slots; first byte lands two slots after line_start.
// Backpressure: requests stop while FIFO occupancy plus the in-flight byte reaches FIFO_DEPTH.
module sdram_vid_fetch
    import sdram_vid_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AW         = 25
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          slot_start,
    input  logic          cpu_win,
    input  logic          line_start,
    input  logic [AW-1:0] line_addr,
    input  logic [5:0]    line_len,
    input  logic          vdg_rd,
    output logic [7:0]    vdg_data,
    output logic          vdg_empty,
    output logic          underrun,
    output logic [AW-1:0] addr2,
    output logic          oe2,
    input  logic [7:0]    dout2
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_M1 = CW'(FIFO_DEPTH - 1);

    fetch_state_t  state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [5:0]    remaining_q, remaining_d;
    logic          low_seen_q, low_seen_d;
    logic          inflight_q, inflight_d;
    logic          discard_q, discard_d;
    logic          oe2_q, oe2_d;
    logic [AW-1:0] addr2_q, addr2_d;
    logic          underrun_q, underrun_d;

    logic          slot_free;
    logic          has_space;
    logic          fifo_push;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    vid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (fifo_push),
        .push_dat (dout2),
        .pop      (vdg_rd),
        .flush    (line_start),
        .rd_dat   (vdg_data),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Request FSM, line bookkeeping and the shadow of the controller's oe2 edge detector
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        low_seen_d  = low_seen_q;
        inflight_d  = inflight_q;
        discard_d   = discard_q;
        oe2_d       = oe2_q;
        addr2_d     = addr2_q;
        underrun_d  = underrun_q;
        fifo_push   = 1'b0;

        // Only free slots update the controller's edge detector, so only they prove oe2 was seen low
        slot_free = slot_start && !cpu_win;
        has_space = inflight_q ? (fifo_count < FULL_M1) : (fifo_count < FULL);

        if (slot_free && !oe2_q) begin
            low_seen_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!line_start && (remaining_q != '0) && low_seen_q && has_space) begin
                    state_d = ST_REQ;
                    oe2_d   = 1'b1;
                    addr2_d = ptr_q;
                end
            end
            ST_REQ: begin
                // A CPU-won slot leaves the edge pending; keep oe2 high and retry next slot
                if (slot_free) begin
                    state_d    = ST_WAIT;
                    oe2_d      = 1'b0;
                    low_seen_d = 1'b0;
                    inflight_d = 1'b1;
                    // A stale request must not consume the freshly loaded line's counters
                    if (!discard_q) begin
                        ptr_d       = ptr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (slot_start) begin
                    state_d    = ST_IDLE;
                    inflight_d = 1'b0;
                    fifo_push  = !discard_q && !line_start;
                    discard_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (line_start) begin
            ptr_d       = line_addr;
            remaining_d = line_len;
            underrun_d  = 1'b0;
            // The handshake in progress runs to completion, but its byte belongs to the old line
            if ((state_q == ST_REQ) || ((state_q == ST_WAIT) && !slot_start)) begin
                discard_d = 1'b1;
            end
        end else if (vdg_rd && fifo_empty) begin
            underrun_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            low_seen_q  <= 1'b0;
            inflight_q  <= 1'b0;
            discard_q   <= 1'b0;
            oe2_q       <= 1'b0;
            addr2_q     <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            low_seen_q  <= low_seen_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            oe2_q       <= oe2_d;
            addr2_q     <= addr2_d;
            underrun_q  <= underrun_d;
        end
    end

    assign oe2       = oe2_q;
    assign addr2     = addr2_q;
    assign underrun  = underrun_q;
    assign vdg_empty = fifo_empty;

endmodule

// File: tb/tb_sdram_vid_fetch.sv
// Self-checking bench for sdram_vid_fetch with a behavioural port-2 controller model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_sdram_vid_fetch;
    import sdram_vid_pkg::*;

    localparam int AW    = 25;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          slot_start;
    logic          cpu_win;
    logic          line_start;
    logic [AW-1:0] line_addr;
    logic [5:0]    line_len;
    logic          vdg_rd;
    logic [7:0]    vdg_data;
    logic          vdg_empty;
    logic          underrun;
    logic [AW-1:0] addr2;
    logic          oe2;
    logic [7:0]    dout2;

    always #5 clk = ~clk;

    sdram_vid_fetch #(
        .FIFO_DEPTH (DEPTH),
        .AW         (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .slot_start (slot_start),
        .cpu_win    (cpu_win),
        .line_start (line_start),
        .line_addr  (line_addr),
        .line_len   (line_len),
        .vdg_rd     (vdg_rd),
        .vdg_data   (vdg_data),
        .vdg_empty  (vdg_empty),
        .underrun   (underrun),
        .addr2      (addr2),
        .oe2        (oe2),
        .dout2      (dout2)
    );

    int checks = 0;
    int errors = 0;

    // Slot generator / controller model state
    int            ph;
    int            slot_idx;
    logic [31:0]   cpu_mask;
    logic          oe2_old;
    logic          oe2_prev;
    int            n_svc;
    int            n_rise;
    int            last_svc_slot;
    logic [7:0]    last_exp;
    logic [AW-1:0] svc_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    sb_q[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [5:0]    len;
        logic [31:0]   mask;
        int            exp_n;
        int            exp_last;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [7:0] fdat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: the controller model acts on what the DUT saw at this edge
    task automatic tick();
        logic          s, c, o;
        logic [AW-1:0] a;
        s = slot_start;
        c = cpu_win;
        o = oe2;
        a = addr2;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        vdg_rd     = 1'b0;
        if (s && !c) begin
            if (o && !oe2_old) begin
                svc_q.push_back(a);
                n_svc++;
                last_svc_slot = slot_idx;
                dout2 = fdat(a);
            end
            oe2_old = o;
        end
        if (oe2 && !oe2_prev) n_rise++;
        oe2_prev = oe2;
        if (s) slot_idx++;
        ph         = (ph == SLOT_LEN - 1) ? 0 : ph + 1;
        slot_start = (ph == 0);
        cpu_win    = slot_start && (slot_idx < 32) && cpu_mask[slot_idx];
    endtask

    task automatic run_slots(input int n);
        repeat (n * SLOT_LEN) tick();
    endtask

    task automatic start_line(input logic [AW-1:0] a, input logic [5:0] len,
                              input logic [31:0] mask, input bit do_align);
        if (do_align) begin
            for (int i = 0; i < SLOT_LEN && !slot_start; i++) tick();
            tick();
        end
        line_addr  = a;
        line_len   = len;
        line_start = 1'b1;
        sb_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < int'(len); i++) begin
            sb_q.push_back(fdat(a + AW'(i)));
            exp_addr_q.push_back(a + AW'(i));
        end
        svc_q.delete();
        n_svc         = 0;
        n_rise        = 0;
        last_svc_slot = -1;
        cpu_mask      = mask;
        slot_idx      = 0;
        tick();
    endtask

    task automatic pop_one(input string name);
        vdg_rd = 1'b1;
        tick();
        if (sb_q.size() > 0) begin
            last_exp = sb_q.pop_front();
            check(name, vdg_data, last_exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: got unexpected byte 0x%0h, none outstanding", name, vdg_data);
        end
    endtask

    task automatic drain(input string name, output int n);
        n = 0;
        for (int i = 0; i < 64 && !vdg_empty; i++) begin
            pop_one(name);
            n++;
        end
    endtask

    task automatic check_addrs(input string name);
        for (int i = 0; i < svc_q.size() && i < exp_addr_q.size(); i++) begin
            check(name, svc_q[i], exp_addr_q[i]);
        end
    endtask

    initial begin
        int k;
        int nd;

        tbl[0] = '{addr: 25'h0001000, len: 6'd4, mask: 32'h0,  exp_n: 4, exp_last: 6};
        tbl[1] = '{addr: 25'h0001100, len: 6'd2, mask: 32'h7,  exp_n: 2, exp_last: 5};
        tbl[2] = '{addr: 25'h0001200, len: 6'd2, mask: 32'h6,  exp_n: 2, exp_last: 4};
        tbl[3] = '{addr: 25'h0001300, len: 6'd0, mask: 32'h0,  exp_n: 0, exp_last: -1};
        tbl[4] = '{addr: 25'h1FFFFFE, len: 6'd4, mask: 32'h0,  exp_n: 4, exp_last: 6};
        tbl[5] = '{addr: 25'h0003000, len: 6'd3, mask: 32'hAA, exp_n: 3, exp_last: 8};

        reset_n    = 1'b0;
        slot_start = 1'b0;
        cpu_win    = 1'b0;
        line_start = 1'b0;
        line_addr  = '0;
        line_len   = '0;
        vdg_rd     = 1'b0;
        dout2      = '0;
        ph         = 0;
        slot_idx   = 0;
        cpu_mask   = '0;
        oe2_old    = 1'b0;
        oe2_prev   = 1'b0;
        n_svc      = 0;
        n_rise     = 0;
        last_svc_slot = -1;
        last_exp   = 8'h00;

        repeat (4) tick();
        check("reset oe2", oe2, 1'b0);
        check("reset addr2", addr2, '0);
        check("reset vdg_data", vdg_data, 8'h00);
        check("reset vdg_empty", vdg_empty, 1'b1);
        check("reset underrun", underrun, 1'b0);
        reset_n = 1'b1;
        run_slots(4);
        check("idle oe2", oe2, 1'b0);

        // Table: one line per entry, fixed CPU slot pattern, no reads until the line settles
        for (int t = 0; t < 6; t++) begin
            start_line(tbl[t].addr, tbl[t].len, tbl[t].mask, 1'b1);
            run_slots(40);
            check($sformatf("t%0d fetches", t), n_svc, tbl[t].exp_n);
            check($sformatf("t%0d oe2 edges", t), n_rise, tbl[t].exp_n);
            check($sformatf("t%0d last svc slot", t), last_svc_slot, tbl[t].exp_last);
            check_addrs($sformatf("t%0d addr2", t));
            check($sformatf("t%0d oe2 idle", t), oe2, 1'b0);
            check($sformatf("t%0d vdg_empty", t), vdg_empty, tbl[t].exp_n == 0);
            drain($sformatf("t%0d data", t), nd);
            check($sformatf("t%0d drained", t), nd, tbl[t].exp_n);
        end

        // First-byte latency with free slots
        start_line(25'h0000400, 6'd1, 32'h0, 1'b1);
        check("first oe2 low at line_start", oe2, 1'b0);
        tick();
        check("first oe2 high", oe2, 1'b1);
        check("first addr2", addr2, 25'h0000400);
        k = 0;
        while (vdg_empty && k < 60) begin tick(); k++; end
        check("first byte latency", k, 10);
        pop_one("first data");

        // Three CPU-won slots while the request is pending
        start_line(25'h0000500, 6'd1, 32'h7, 1'b1);
        tick();
        check("cpu oe2 high", oe2, 1'b1);
        k = 0;
        while (vdg_empty && k < 80) begin tick(); k++; end
        check("cpu byte latency", k, 28);
        check("cpu single edge", n_rise, 1);
        check("cpu single fetch", n_svc, 1);
        pop_one("cpu data");

        // line_start while WAIT: stale byte dropped, new line starts at its own address
        start_line(25'h0001400, 6'd3, 32'h0, 1'b1);
        for (int i = 0; i < 60 && n_svc == 0; i++) tick();
        check("discard setup fetch", n_svc, 1);
        start_line(25'h0002000, 6'd2, 32'h0, 1'b0);
        repeat (6) tick();
        check("discard empty", vdg_empty, 1'b1);
        run_slots(20);
        check("discard fetches", n_svc, 2);
        check_addrs("discard addr2");
        drain("discard data", nd);
        check("discard drained", nd, 2);

        // Long line with no reads: FIFO fills, one pop allows one more fetch
        start_line(25'h0004000, 6'd40, 32'h0, 1'b1);
        run_slots(40);
        check("full fetches", n_svc, DEPTH);
        check("full oe2 idle", oe2, 1'b0);
        pop_one("full pop");
        run_slots(4);
        check("refill fetch", n_svc, DEPTH + 1);
        run_slots(4);
        check("refill stops", n_svc, DEPTH + 1);
        check_addrs("full addr2");
        drain("full data", nd);
        start_line('0, 6'd0, 32'h0, 1'b1);
        check("flush empty", vdg_empty, 1'b1);

        // Underrun: sticky until line_start, vdg_data holds
        vdg_rd = 1'b1;
        tick();
        check("underrun set", underrun, 1'b1);
        check("underrun data held", vdg_data, last_exp);
        run_slots(1);
        check("underrun sticky", underrun, 1'b1);
        start_line('0, 6'd0, 32'h0, 1'b1);
        check("underrun cleared", underrun, 1'b0);

        // line_start and vdg_rd together: flush wins, pop ignored
        start_line(25'h0005000, 6'd1, 32'h0, 1'b1);
        for (int i = 0; i < 80 && vdg_empty; i++) tick();
        check("collide setup filled", vdg_empty, 1'b0);
        vdg_rd = 1'b1;
        start_line('0, 6'd0, 32'h0, 1'b0);
        check("collide empty", vdg_empty, 1'b1);
        check("collide data held", vdg_data, last_exp);
        check("collide no underrun", underrun, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
